// File: rtl/shift_arb_if.sv
// Requester handshakes, per-requester responses and the shared-shifter drive bundle for shift_arb.
interface shift_arb_if;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned PARAM_W = 7;
    localparam int unsigned WIDE_W  = 11;
    localparam int unsigned OP_W    = 2;

    logic               a_valid;
    logic               a_ready;
    logic [DATA_W-1:0]  a_in;
    logic [PARAM_W-1:0] a_param;
    logic [WIDE_W-1:0]  a_wide;
    logic [OP_W-1:0]    a_op;

    logic               b_valid;
    logic               b_ready;
    logic [DATA_W-1:0]  b_in;
    logic [PARAM_W-1:0] b_param;
    logic [WIDE_W-1:0]  b_wide;
    logic [OP_W-1:0]    b_op;

    logic               a_rsp_valid;
    logic               b_rsp_valid;
    logic               a_rsp_ready;
    logic               b_rsp_ready;
    logic [DATA_W-1:0]  rsp_data;

    logic [DATA_W-1:0]  sh_in;
    logic [PARAM_W-1:0] sh_param;
    logic [WIDE_W-1:0]  sh_wide;
    logic [OP_W-1:0]    sh_op;
    logic [DATA_W-1:0]  sh_out;

    logic               busy;

    modport slave (
        input  a_valid, a_in, a_param, a_wide, a_op,
        input  b_valid, b_in, b_param, b_wide, b_op,
        input  a_rsp_ready, b_rsp_ready, sh_out,
        output a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_data,
        output sh_in, sh_param, sh_wide, sh_op, busy
    );

    modport master (
        output a_valid, a_in, a_param, a_wide, a_op,
        output b_valid, b_in, b_param, b_wide, b_op,
        output a_rsp_ready, b_rsp_ready, sh_out,
        input  a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_data,
        input  sh_in, sh_param, sh_wide, sh_op, busy
    );
endinterface

// File: rtl/shift_arb.sv
// Two-requester arbiter in front of one shared combinational 64-bit shifter (IDLE/ISSUE/HOLD).
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed A-over-B priority; default build is round-robin.
module shift_arb (
    input  logic       clk,
    input  logic       rst_n,
    shift_arb_if.slave io_bus
);
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned PARAM_W = 7;
    localparam int unsigned WIDE_W  = 11;
    localparam int unsigned OP_W    = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_owner_b;
    logic               r_busy;
    logic               r_a_rsp_valid;
    logic               r_b_rsp_valid;
    logic [DATA_W-1:0]  r_sh_in;
    logic [PARAM_W-1:0] r_sh_param;
    logic [WIDE_W-1:0]  r_sh_wide;
    logic [OP_W-1:0]    r_sh_op;
    logic [DATA_W-1:0]  r_rsp_data;

    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_owner_rdy;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic               r_ptr_b;
`endif

    // Grant decode; ready is gated by rst_n so it drops immediately while reset is held.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (rst_n && (r_state == S_IDLE)) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            if (io_bus.a_valid) begin
                w_grant_a = 1'b1;
            end else if (io_bus.b_valid) begin
                w_grant_b = 1'b1;
            end
`else
            if (io_bus.a_valid && (!io_bus.b_valid || !r_ptr_b)) begin
                w_grant_a = 1'b1;
            end else if (io_bus.b_valid) begin
                w_grant_b = 1'b1;
            end
`endif
        end
    end

    assign w_owner_rdy = r_owner_b ? io_bus.b_rsp_ready : io_bus.a_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_owner_b     <= 1'b0;
            r_busy        <= 1'b0;
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_sh_in       <= '0;
            r_sh_param    <= '0;
            r_sh_wide     <= '0;
            r_sh_op       <= '0;
            r_rsp_data    <= '0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            r_ptr_b       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_a || w_grant_b) begin
                        r_state    <= S_ISSUE;
                        r_busy     <= 1'b1;
                        r_owner_b  <= w_grant_b;
                        r_sh_in    <= w_grant_b ? io_bus.b_in    : io_bus.a_in;
                        r_sh_param <= w_grant_b ? io_bus.b_param : io_bus.a_param;
                        r_sh_wide  <= w_grant_b ? io_bus.b_wide  : io_bus.a_wide;
                        r_sh_op    <= w_grant_b ? io_bus.b_op    : io_bus.a_op;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
                        // Favour whichever requester was not just served.
                        r_ptr_b    <= w_grant_a;
`endif
                    end
                end
                S_ISSUE: begin
                    r_state       <= S_HOLD;
                    r_rsp_data    <= io_bus.sh_out;
                    r_a_rsp_valid <= !r_owner_b;
                    r_b_rsp_valid <= r_owner_b;
                end
                S_HOLD: begin
                    if (w_owner_rdy) begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_a_rsp_valid <= 1'b0;
                        r_b_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_busy        <= 1'b0;
                    r_a_rsp_valid <= 1'b0;
                    r_b_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.a_ready     = w_grant_a;
    assign io_bus.b_ready     = w_grant_b;
    assign io_bus.a_rsp_valid = r_a_rsp_valid;
    assign io_bus.b_rsp_valid = r_b_rsp_valid;
    assign io_bus.rsp_data    = r_rsp_data;
    assign io_bus.sh_in       = r_sh_in;
    assign io_bus.sh_param    = r_sh_param;
    assign io_bus.sh_wide     = r_sh_wide;
    assign io_bus.sh_op       = r_sh_op;
    assign io_bus.busy        = r_busy;
endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb: accept-time scoreboard against a reference shifter model.
module tb_shift_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_arb_if bus();

    shift_arb dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct packed {
        logic        owner_b;
        logic [63:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    logic grant_log[$];
    int   viol = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference shifter: 0 shl, 1 shr, 2 sra, 3 rotate right; amount is param[5:0].
    function automatic logic [63:0] shf(input logic [63:0] d, input logic [6:0] p, input logic [1:0] op);
        logic [5:0] s;
        s = p[5:0];
        case (op)
            2'd0:    shf = d << s;
            2'd1:    shf = d >> s;
            2'd2:    shf = 64'($signed(d) >>> s);
            default: shf = (d >> s) | (d << (7'd64 - 7'(s)));
        endcase
    endfunction

    assign bus.sh_out = shf(bus.sh_in, bus.sh_param, bus.sh_op);

    // Scoreboard feed: expectations at accept, observations at response handshake.
    always @(negedge clk) begin
        if (bus.a_ready && bus.b_ready) viol++;
        if (bus.a_rsp_valid && bus.b_rsp_valid) viol++;
        if ((bus.a_ready || bus.b_ready) && bus.busy) viol++;
        if ((bus.a_rsp_valid || bus.b_rsp_valid) && exp_q.size() == 0) viol++;
        if (bus.a_valid && bus.a_ready) begin
            exp_q.push_back('{1'b0, shf(bus.a_in, bus.a_param, bus.a_op)});
            grant_log.push_back(1'b0);
        end else if (bus.b_valid && bus.b_ready) begin
            exp_q.push_back('{1'b1, shf(bus.b_in, bus.b_param, bus.b_op)});
            grant_log.push_back(1'b1);
        end
        if (bus.a_rsp_valid && bus.a_rsp_ready) got_q.push_back('{1'b0, bus.rsp_data});
        if (bus.b_rsp_valid && bus.b_rsp_ready) got_q.push_back('{1'b1, bus.rsp_data});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        bus.a_in = '0; bus.a_param = '0; bus.a_wide = '0; bus.a_op = '0;
        bus.b_in = '0; bus.b_param = '0; bus.b_wide = '0; bus.b_op = '0;
        bus.a_rsp_ready = 1'b1; bus.b_rsp_ready = 1'b1;
        #12;
        n_checks++;
        if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b required 00", {bus.a_ready, bus.b_ready});
        end
        n_checks++;
        if ({bus.busy, bus.a_rsp_valid, bus.b_rsp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.a_rsp_valid, bus.b_rsp_valid});
        end
        n_checks++;
        if ({bus.sh_in, bus.sh_param, bus.sh_wide, bus.sh_op} !== '0) begin
            n_fail++; $display("FAIL reset_sh: got %h required 0", {bus.sh_in, bus.sh_param, bus.sh_wide, bus.sh_op});
        end
        n_checks++;
        if (bus.rsp_data !== 64'h0) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h required 0", bus.rsp_data);
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        rsp_t g, e;
        @(posedge clk); #1;
        bus.a_valid = 1'b1; bus.a_in = 64'hF0; bus.a_param = 7'h44; bus.a_wide = 11'h5A5; bus.a_op = 2'd1;
        @(negedge clk);
        n_checks++;
        if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
            n_fail++; $display("FAIL single_ready: got %b required 10", {bus.a_ready, bus.b_ready});
        end
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.sh_in, bus.sh_param, bus.sh_wide, bus.sh_op} !== {64'hF0, 7'h44, 11'h5A5, 2'd1}) begin
            n_fail++; $display("FAIL single_sh: got %h/%h/%h/%h required f0/44/5a5/1",
                               bus.sh_in, bus.sh_param, bus.sh_wide, bus.sh_op);
        end
        n_checks++;
        if ({bus.busy, bus.a_rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL single_issue: got busy,valid=%b required 10", {bus.busy, bus.a_rsp_valid});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.a_rsp_valid, bus.b_rsp_valid, bus.rsp_data} !== {2'b10, 64'h0F}) begin
            n_fail++; $display("FAIL single_rsp: got %b %h required 10 f", {bus.a_rsp_valid, bus.b_rsp_valid}, bus.rsp_data);
        end
        for (int k = 0; k < 20 && got_q.size() < 1; k++) @(posedge clk);
        n_checks++;
        if (got_q.size() < 1 || exp_q.size() < 1) begin
            n_fail++; $display("FAIL single_sb: got %0d responses required 1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin
                n_fail++; $display("FAIL single_sb: got %b/%h required %b/%h", g.owner_b, g.data, e.owner_b, e.data);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: busy got %b required 0", bus.busy);
        end
    endtask

    task automatic test_backpressure();
        rsp_t g, e;
        logic [63:0] want;
        want = shf(64'hDEAD_BEEF_0000_1234, 7'h08, 2'd0);
        @(posedge clk); #1;
        bus.b_rsp_ready = 1'b0;
        bus.b_valid = 1'b1; bus.b_in = 64'hDEAD_BEEF_0000_1234; bus.b_param = 7'h08; bus.b_wide = 11'h011; bus.b_op = 2'd0;
        @(negedge clk);
        n_checks++;
        if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_ready: got %b required 01", {bus.a_ready, bus.b_ready});
        end
        @(posedge clk); #1;
        bus.b_valid = 1'b0;
        @(posedge clk); #1;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.b_rsp_valid, bus.a_rsp_valid, bus.rsp_data} !== {2'b10, want}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %b %h required 10 %h", c,
                                   {bus.b_rsp_valid, bus.a_rsp_valid}, bus.rsp_data, want);
            end
            n_checks++;
            if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
                n_fail++; $display("FAIL bp_no_ready[%0d]: got %b required 00", c, {bus.a_ready, bus.b_ready});
            end
            @(posedge clk); #1;
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.b_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.b_rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL bp_release: got busy,valid=%b required 00", {bus.busy, bus.b_rsp_valid});
        end
        for (int k = 0; k < 20 && got_q.size() < 1; k++) @(posedge clk);
        n_checks++;
        if (got_q.size() < 1 || exp_q.size() < 1) begin
            n_fail++; $display("FAIL bp_sb: got %0d responses required 1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e || e.data !== want) begin
                n_fail++; $display("FAIL bp_sb: got %b/%h required %b/%h", g.owner_b, g.data, e.owner_b, want);
            end
        end
    endtask

    task automatic test_contention();
        rsp_t g, e;
        logic want_b;
        grant_log.delete();
        @(posedge clk); #1;
        bus.a_valid = 1'b1; bus.a_in = 64'h8000_0000_0000_0001; bus.a_param = 7'h01; bus.a_op = 2'd3;
        bus.b_valid = 1'b1; bus.b_in = 64'hF000_0000_0000_0000; bus.b_param = 7'h04; bus.b_op = 2'd2;
        for (int k = 0; k < 60 && grant_log.size() < 4; k++) begin
            @(posedge clk); #1;
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 4; k++) @(posedge clk);
        n_checks++;
        if (grant_log.size() != 4 || got_q.size() != 4) begin
            n_fail++; $display("FAIL cont_count: got %0d grants %0d responses required 4 4", grant_log.size(), got_q.size());
        end
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            want_b = 1'b0;
`else
            want_b = (i % 2) == 1;
`endif
            n_checks++;
            if (grant_log[i] !== want_b) begin
                n_fail++; $display("FAIL cont_order[%0d]: got %s required %s", i,
                                   grant_log[i] ? "B" : "A", want_b ? "B" : "A");
            end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++; $display("FAIL cont_sb: got %b/%h required %b/%h", g.owner_b, g.data, e.owner_b, e.data);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        bus.a_rsp_ready = 1'b0;
        bus.a_valid = 1'b1; bus.a_in = 64'h0123_4567_89AB_CDEF; bus.a_param = 7'h10; bus.a_wide = 11'h7FF; bus.a_op = 2'd0;
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.a_rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: a_rsp_valid got %b required 1", bus.a_rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.a_rsp_valid, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL arst_drop: got valid,busy=%b required 00", {bus.a_rsp_valid, bus.busy});
        end
        n_checks++;
        if ({bus.sh_in, bus.sh_param, bus.sh_wide, bus.sh_op, bus.rsp_data} !== '0) begin
            n_fail++; $display("FAIL arst_clear: got sh_in %h rsp_data %h required 0", bus.sh_in, bus.rsp_data);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; bus.a_rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.a_rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL arst_idle: got busy,valid=%b required 00", {bus.busy, bus.a_rsp_valid});
        end
        repeat (6) @(posedge clk);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++; $display("FAIL arst_stale: got %0d responses required 0", got_q.size());
        end
    endtask

    task automatic test_withdrawal();
        rsp_t g, e;
        grant_log.delete();
        @(posedge clk); #1;
        bus.b_valid = 1'b1; bus.b_in = 64'h00FF_00FF_00FF_00FF; bus.b_param = 7'h08; bus.b_op = 2'd3;
        @(posedge clk); #1;
        bus.b_valid = 1'b0; bus.a_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.a_ready !== 1'b0) begin
            n_fail++; $display("FAIL wd_ready: a_ready got %b required 0", bus.a_ready);
        end
        @(posedge clk); #1;
        bus.a_valid = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 1; k++) @(posedge clk);
        @(posedge clk); #1;
        bus.b_valid = 1'b1; bus.b_in = 64'h8000_0000_0000_0000; bus.b_param = 7'h3F; bus.b_op = 2'd2;
        @(posedge clk); #1;
        bus.b_valid = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 2; k++) @(posedge clk);
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 1'b1 || grant_log[1] !== 1'b1) begin
            n_fail++; $display("FAIL wd_grants: got %0d grants required 2 to B", grant_log.size());
        end
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL wd_count: got %0d responses required 2", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (g !== e || g.owner_b !== 1'b1) begin
                n_fail++; $display("FAIL wd_sb: got %b/%h required 1/%h", g.owner_b, g.data, e.data);
            end
        end
    endtask

    task automatic test_protocol();
        repeat (2) @(posedge clk);
        n_checks++;
        if (viol != 0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL protocol: got %0d violations %0d pending required 0 0", viol, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_async_reset();
        test_withdrawal();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
